// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_pkg
//  Purpose  : Shared widths, vector type and startup states for the
//             seven-sensor debounce front end.
//  Revision : 1.0  initial release
// ============================================================================
package sensor_pkg;

    localparam int NUM_SENSORS  = 7;
    localparam int SYNC_STAGES  = 2;
    localparam int GLITCH_CNT_W = 4;

    typedef logic [NUM_SENSORS-1:0] sensor_vec_t;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } startup_state_t;

endpackage : sensor_pkg
`default_nettype wire

// File: rtl/sensor_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_debounce_bit
//  Purpose  : One sensor line: synchroniser, debounce counter, change pulse,
//             and (with CHATTER_DETECT_EN defined) glitch counting and a
//             sticky fault flag.
//  Revision : 1.0  initial release
// ============================================================================
module sensor_debounce_bit
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_LIMIT    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_x_clean,
    output logic o_chg,
    output logic o_fault
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
        GLITCH_LIMIT < 1 || GLITCH_LIMIT > 15) begin : g_bad_params
        $error("sensor_debounce_bit: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_x_clean;
    logic                   r_chg;
    logic                   w_synced;
    logic                   w_differs;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_synced != r_x_clean);

    // Sync flops reset high so a healthy line produces no startup transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_x_clean <= 1'b1;
            r_chg     <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            if (w_differs) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_x_clean <= w_synced;
                    r_cnt     <= '0;
                    r_chg     <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_x_clean = r_x_clean;
    assign o_chg     = r_chg;

`ifdef CHATTER_DETECT_EN
    localparam logic [GLITCH_CNT_W-1:0] c_GLITCH_MAX  = '1;
    localparam logic [GLITCH_CNT_W-1:0] c_GLITCH_TRIP = GLITCH_CNT_W'(GLITCH_LIMIT - 1);

    logic [GLITCH_CNT_W-1:0] r_glitch_cnt;
    logic                    r_fault;
    logic                    w_glitch;

    // A level that falls back to the clean value mid-count is an aborted edge.
    assign w_glitch = !w_differs && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= '0;
            r_fault      <= 1'b0;
        end else if (w_glitch) begin
            if (r_glitch_cnt != c_GLITCH_MAX) begin
                r_glitch_cnt <= r_glitch_cnt + 1'b1;
            end
            if (r_glitch_cnt == c_GLITCH_TRIP) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_fault = r_fault;
`else
    assign o_fault = 1'b0;
`endif

endmodule : sensor_debounce_bit
`default_nettype wire

// File: rtl/seven_sensor_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : seven_sensor_debounce
//  Purpose  : Conditions seven raw sensor lines for the SOP voter and flags
//             when outputs are trustworthy after reset. Optional chatter
//             detection is enabled by defining CHATTER_DETECT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module seven_sensor_debounce
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_LIMIT    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] raw,
    output logic [NUM_SENSORS-1:0] x_clean,
    output logic [NUM_SENSORS-1:0] chg,
    output logic                   settled,
    output logic [NUM_SENSORS-1:0] fault
);

    localparam int c_PHASE_W = 8;
    // Fill lasts as long as the synchroniser takes to carry live data.
    localparam logic [c_PHASE_W-1:0] c_FILL_LAST   = c_PHASE_W'(SYNC_STAGES - 1);
    localparam logic [c_PHASE_W-1:0] c_SETTLE_LAST = c_PHASE_W'(DEBOUNCE_CYCLES - 1);

    sensor_vec_t w_x_clean;
    sensor_vec_t w_chg;
    sensor_vec_t w_fault;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sensor
        sensor_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .GLITCH_LIMIT    (GLITCH_LIMIT)
        ) u_bit (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (raw[i]),
            .o_x_clean (w_x_clean[i]),
            .o_chg     (w_chg[i]),
            .o_fault   (w_fault[i])
        );
    end

    startup_state_t       r_state;
    startup_state_t       w_state_next;
    logic [c_PHASE_W-1:0] r_phase;
    logic [c_PHASE_W-1:0] w_phase_next;
    logic                 r_settled;

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase + 1'b1;
        case (r_state)
            S_FILL: begin
                if (r_phase == c_FILL_LAST) begin
                    w_state_next = S_SETTLE;
                    w_phase_next = '0;
                end
            end
            S_SETTLE: begin
                if (r_phase == c_SETTLE_LAST) begin
                    w_state_next = S_RUN;
                    w_phase_next = '0;
                end
            end
            S_RUN: begin
                w_phase_next = '0;
            end
            default: begin
                w_state_next = S_FILL;
                w_phase_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FILL;
            r_phase   <= '0;
            r_settled <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_phase   <= w_phase_next;
            r_settled <= (w_state_next == S_RUN);
        end
    end

    assign x_clean = w_x_clean;
    assign chg     = w_chg;
    assign fault   = w_fault;
    assign settled = r_settled;

endmodule : seven_sensor_debounce
`default_nettype wire
